// File: rtl/systolic_sequencer.sv
// Command sequencer for a LANES-wide systolic array: streams weight and data
// rows, buffers result rows in a 4-deep FIFO and supervises completion.
module systolic_sequencer #(
   parameter int LANES = 16,
   parameter int DW    = 8,
   parameter int RW    = 16,
   parameter int TMO   = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [3:0]            cmd_rows,
   input  logic [3:0]            cmd_cols,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*DW-1:0]   in_row,
   output logic                  sa_start,
   output logic [1:0]            sa_operation,
   output logic [3:0]            sa_rows,
   output logic [3:0]            sa_cols,
   output logic [LANES*DW-1:0]   sa_weight,
   output logic                  sa_weight_valid,
   output logic [LANES*DW-1:0]   sa_data,
   output logic                  sa_data_valid,
   input  logic [LANES*RW-1:0]   sa_result,
   input  logic                  sa_result_valid,
   input  logic                  sa_done,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [LANES*RW-1:0]   res_row,
   output logic [3:0]            res_index,
   output logic                  busy,
   output logic                  done,
   output logic                  cmd_err,
   output logic                  err_overflow,
   output logic                  err_timeout
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_LOAD_W  = 3'd2;
   localparam logic [2:0] S_FEED_D  = 3'd3;
   localparam logic [2:0] S_COLLECT = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   // Timeout counter only has to reach TMO-1.
   localparam int TW = (TMO < 2) ? 1 : $clog2(TMO);

   logic [2:0]          state;
   logic [1:0]          op_q;
   logic [3:0]          rows_q;
   logic [3:0]          cols_q;
   logic [3:0]          beat_cnt;
   logic                done_seen;
   logic [TW-1:0]       tmo_cnt;

   logic [LANES*RW-1:0] fifo_row [4];
   logic [3:0]          fifo_idx [4];
   logic [1:0]          wr_ptr;
   logic [1:0]          rd_ptr;
   logic [2:0]          fifo_cnt;
   logic [3:0]          idx_cnt;

   logic cmd_bad, cmd_start, beat, last_beat, collecting;
   logic push_req, push, pop, full;

   assign cmd_bad    = (cmd_op >= 2'd2) || (cmd_rows == 4'd0) || (cmd_cols == 4'd0);
   assign cmd_start  = (state == S_IDLE) && cmd_valid && !cmd_bad;
   assign beat       = in_valid && in_ready;
   assign last_beat  = beat && (beat_cnt == rows_q - 4'd1);
   assign collecting = (state != S_IDLE) && (state != S_DONE);

   assign full     = (fifo_cnt == 3'd4);
   assign pop      = res_ready && res_valid;
   assign push_req = collecting && sa_result_valid;
   assign push     = push_req && (!full || pop);

   assign cmd_ready    = (state == S_IDLE);
   assign busy         = (state != S_IDLE);
   assign in_ready     = (state == S_LOAD_W) || (state == S_FEED_D);
   assign sa_start     = (state == S_START);
   assign done         = (state == S_DONE);
   assign sa_operation = busy ? op_q   : 2'd0;
   assign sa_rows      = busy ? rows_q : 4'd0;
   assign sa_cols      = busy ? cols_q : 4'd0;

   assign res_valid = (fifo_cnt != 3'd0);
   assign res_row   = res_valid ? fifo_row[rd_ptr] : '0;
   assign res_index = res_valid ? fifo_idx[rd_ptr] : 4'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         op_q            <= 2'd0;
         rows_q          <= 4'd0;
         cols_q          <= 4'd0;
         beat_cnt        <= 4'd0;
         done_seen       <= 1'b0;
         tmo_cnt         <= '0;
         sa_weight       <= '0;
         sa_weight_valid <= 1'b0;
         sa_data         <= '0;
         sa_data_valid   <= 1'b0;
         cmd_err         <= 1'b0;
         err_timeout     <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low each cycle; the case below only raises them.
         sa_weight_valid <= 1'b0;
         sa_data_valid   <= 1'b0;
         cmd_err         <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_bad) begin
                  cmd_err <= 1'b1;
               end else if (cmd_valid) begin
                  op_q        <= cmd_op;
                  rows_q      <= cmd_rows;
                  cols_q      <= cmd_cols;
                  beat_cnt    <= 4'd0;
                  done_seen   <= 1'b0;
                  err_timeout <= 1'b0;
                  state       <= S_START;
               end
            end
            S_START: state <= S_LOAD_W;
            S_LOAD_W: begin
               if (beat) begin
                  sa_weight       <= in_row;
                  sa_weight_valid <= 1'b1;
                  beat_cnt        <= last_beat ? 4'd0 : beat_cnt + 4'd1;
                  if (last_beat) state <= S_FEED_D;
               end
            end
            S_FEED_D: begin
               if (beat) begin
                  sa_data       <= in_row;
                  sa_data_valid <= 1'b1;
                  beat_cnt      <= last_beat ? 4'd0 : beat_cnt + 4'd1;
                  if (last_beat) begin
                     tmo_cnt <= '0;
                     state   <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (sa_done || done_seen) begin
                  state <= S_DONE;
               end else if (tmo_cnt == TW'(TMO - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         // An early done from the array is remembered until COLLECT can act on it.
         if (sa_done && (state == S_START || state == S_LOAD_W || state == S_FEED_D))
            done_seen <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cmd_start) begin
         wr_ptr       <= 2'd0;
         rd_ptr       <= 2'd0;
         fifo_cnt     <= 3'd0;
         idx_cnt      <= 4'd0;
         err_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr  <= wr_ptr + 2'd1;
            idx_cnt <= idx_cnt + 4'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         if (push_req && !push) err_overflow <= 1'b1;
         if (push && !pop)      fifo_cnt <= fifo_cnt + 3'd1;
         else if (pop && !push) fifo_cnt <= fifo_cnt - 3'd1;
      end
   end

   // NOTE: FIFO storage is not reset; res_valid gates every read of it.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_row[wr_ptr] <= sa_result;
         fifo_idx[wr_ptr] <= idx_cnt;
      end
   end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized bench for systolic_sequencer: a transaction-level model predicts
// array traffic, result-FIFO contents, indices and error flags.
module tb_systolic_sequencer;

   localparam int LANES = 4;
   localparam int DW    = 8;
   localparam int RW    = 16;
   localparam int TMO   = 40;

   logic                  clk;
   logic                  rst;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [3:0]            cmd_rows;
   logic [3:0]            cmd_cols;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*DW-1:0]   in_row;
   logic                  sa_start;
   logic [1:0]            sa_operation;
   logic [3:0]            sa_rows;
   logic [3:0]            sa_cols;
   logic [LANES*DW-1:0]   sa_weight;
   logic                  sa_weight_valid;
   logic [LANES*DW-1:0]   sa_data;
   logic                  sa_data_valid;
   logic [LANES*RW-1:0]   sa_result;
   logic                  sa_result_valid;
   logic                  sa_done;
   logic                  res_valid;
   logic                  res_ready;
   logic [LANES*RW-1:0]   res_row;
   logic [3:0]            res_index;
   logic                  busy;
   logic                  done;
   logic                  cmd_err;
   logic                  err_overflow;
   logic                  err_timeout;

   systolic_sequencer #(.LANES(LANES), .DW(DW), .RW(RW), .TMO(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rows(cmd_rows), .cmd_cols(cmd_cols),
      .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
      .sa_start(sa_start), .sa_operation(sa_operation), .sa_rows(sa_rows),
      .sa_cols(sa_cols), .sa_weight(sa_weight), .sa_weight_valid(sa_weight_valid),
      .sa_data(sa_data), .sa_data_valid(sa_data_valid),
      .sa_result(sa_result), .sa_result_valid(sa_result_valid), .sa_done(sa_done),
      .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
      .res_index(res_index), .busy(busy), .done(done), .cmd_err(cmd_err),
      .err_overflow(err_overflow), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model of the result FIFO.
   logic [LANES*RW-1:0] mq_row [$];
   logic [3:0]          mq_idx [$];
   int                  m_idx;
   bit                  m_ovf;

   // Observed array-side traffic.
   int                  n_start = 0;
   int                  n_done  = 0;
   logic [LANES*DW-1:0] w_seen [$];
   logic [LANES*DW-1:0] d_seen [$];

   always @(negedge clk) begin
      if (!rst) begin
         if (sa_start)        n_start <= n_start + 1;
         if (done)            n_done  <= n_done + 1;
         if (sa_weight_valid) w_seen.push_back(sa_weight);
         if (sa_data_valid)   d_seen.push_back(sa_data);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq_row.delete();
      mq_idx.delete();
      m_idx = 0;
      m_ovf = 1'b0;
   endtask

   // One clock: apply the FIFO rules to the current inputs, then advance.
   task automatic clk_cycle();
      bit pop;
      pop = res_ready && (mq_row.size() > 0);
      if (pop) begin
         check("res_valid", 64'(res_valid), 64'd1);
         check("res_row", 64'(res_row), 64'(mq_row[0]));
         check("res_index", 64'(res_index), 64'(mq_idx[0]));
         void'(mq_row.pop_front());
         void'(mq_idx.pop_front());
      end
      if (sa_result_valid && !rst) begin
         if (mq_row.size() < 4) begin
            mq_row.push_back(sa_result);
            mq_idx.push_back(4'(m_idx));
            m_idx = (m_idx + 1) % 16;
         end else begin
            m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_sa_start"}, 64'(sa_start), 64'd0);
      check({tag, "_sa_op"}, 64'(sa_operation), 64'd0);
      check({tag, "_sa_rows"}, 64'(sa_rows), 64'd0);
      check({tag, "_sa_cols"}, 64'(sa_cols), 64'd0);
      check({tag, "_sa_weight"}, 64'(sa_weight), 64'd0);
      check({tag, "_sa_wvalid"}, 64'(sa_weight_valid), 64'd0);
      check({tag, "_sa_data"}, 64'(sa_data), 64'd0);
      check({tag, "_sa_dvalid"}, 64'(sa_data_valid), 64'd0);
      check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
      check({tag, "_res_row"}, 64'(res_row), 64'd0);
      check({tag, "_res_index"}, 64'(res_index), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_cmd_err"}, 64'(cmd_err), 64'd0);
      check({tag, "_err_ovf"}, 64'(err_overflow), 64'd0);
      check({tag, "_err_tmo"}, 64'(err_timeout), 64'd0);
   endtask

   task automatic bad_cmd(input logic [1:0] op, input logic [3:0] rows, input logic [3:0] cols);
      int s0;
      s0 = n_start;
      res_ready = 1'b0;
      check("bad_cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_rows = rows; cmd_cols = cols;
      clk_cycle();
      cmd_valid = 1'b0;
      check("bad_cmd_err", 64'(cmd_err), 64'd1);
      check("bad_busy", 64'(busy), 64'd0);
      clk_cycle();
      check("bad_cmd_err_len", 64'(cmd_err), 64'd0);
      check("bad_busy2", 64'(busy), 64'd0);
      check("bad_no_start", 64'(n_start), 64'(s0));
   endtask

   // mode 0: results then sa_done; 1: sa_done during START; 2: sa_done withheld.
   // rdy_pct < 0 pops only when the model FIFO is full.
   task automatic run_txn(input logic [1:0] op, input logic [3:0] rows, input logic [3:0] cols,
                          input int nres, input int mode, input int rdy_pct);
      logic [LANES*DW-1:0] w [$];
      logic [LANES*DW-1:0] d [$];
      int s0, dn0, guard;
      s0  = n_start;
      dn0 = n_done;
      w_seen.delete();
      d_seen.delete();
      res_ready = 1'b0;
      check("txn_cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_rows = rows; cmd_cols = cols;
      model_clear();
      clk_cycle();
      cmd_valid = 1'b0;
      check("start_pulse", 64'(sa_start), 64'd1);
      check("start_busy", 64'(busy), 64'd1);
      check("start_cmd_ready", 64'(cmd_ready), 64'd0);
      if (mode == 1) sa_done = 1'b1;
      clk_cycle();
      sa_done = 1'b0;
      check("start_len", 64'(sa_start), 64'd0);
      check("sa_operation", 64'(sa_operation), 64'(op));
      check("sa_rows", 64'(sa_rows), 64'(rows));
      check("sa_cols", 64'(sa_cols), 64'(cols));
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < int'(rows); i++) begin
            if ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               clk_cycle();
            end
            check("in_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_row   = $urandom;
            if (ph == 0) w.push_back(in_row);
            else         d.push_back(in_row);
            clk_cycle();
            in_valid = 1'b0;
         end
      end
      check("collect_in_ready", 64'(in_ready), 64'd0);
      if (mode == 2) begin
         repeat (TMO - 1) clk_cycle();
         check("tmo_not_yet", 64'(err_timeout), 64'd0);
         check("tmo_busy_before", 64'(busy), 64'd1);
         clk_cycle();
         check("tmo_flag", 64'(err_timeout), 64'd1);
         check("tmo_idle", 64'(busy), 64'd0);
         check("tmo_cmd_ready", 64'(cmd_ready), 64'd1);
      end else begin
         if (mode == 0) begin
            for (int k = 0; k < nres; k++) begin
               sa_result_valid = 1'b1;
               sa_result = {$urandom, $urandom};
               if (rdy_pct < 0) res_ready = (mq_row.size() == 4);
               else             res_ready = ($urandom_range(0, 99) < rdy_pct);
               clk_cycle();
            end
            sa_result_valid = 1'b0;
            res_ready = 1'b0;
            sa_done = 1'b1;
            clk_cycle();
            sa_done = 1'b0;
         end else begin
            clk_cycle();
         end
         check("done_pulse", 64'(done), 64'd1);
         check("done_busy", 64'(busy), 64'd1);
         check("done_sa_rows", 64'(sa_rows), 64'(rows));
         clk_cycle();
         check("done_len", 64'(done), 64'd0);
         check("post_busy", 64'(busy), 64'd0);
         check("post_err_tmo", 64'(err_timeout), 64'd0);
      end
      check("done_count", 64'(n_done - dn0), (mode == 2) ? 64'd0 : 64'd1);
      check("start_count", 64'(n_start - s0), 64'd1);
      check("err_overflow", 64'(err_overflow), 64'(m_ovf));
      check("w_count", 64'(w_seen.size()), 64'(rows));
      check("d_count", 64'(d_seen.size()), 64'(rows));
      for (int i = 0; i < int'(rows); i++) begin
         if (i < w_seen.size()) check("w_row", 64'(w_seen[i]), 64'(w[i]));
         if (i < d_seen.size()) check("d_row", 64'(d_seen[i]), 64'(d[i]));
      end
      res_ready = 1'b1;
      guard = 0;
      while (mq_row.size() > 0 && guard < 8) begin
         clk_cycle();
         guard++;
      end
      res_ready = 1'b0;
      check("drained", 64'(res_valid), 64'd0);
   endtask

   task automatic reset_mid_feed();
      int s0, dcount;
      res_ready = 1'b0;
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rows = 4'd3; cmd_cols = 4'd3;
      model_clear();
      clk_cycle();
      cmd_valid = 1'b0;
      clk_cycle();
      repeat (4) begin
         in_valid = 1'b1;
         in_row   = $urandom;
         clk_cycle();
      end
      in_valid = 1'b0;
      check("rst_pre_busy", 64'(busy), 64'd1);
      check("rst_pre_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b1;
      clk_cycle();
      check_idle("rst_mid");
      rst = 1'b0;
      model_clear();
      s0 = n_start;
      dcount = d_seen.size();
      repeat (4) clk_cycle();
      check("rst_no_start", 64'(n_start), 64'(s0));
      check("rst_no_data", 64'(d_seen.size()), 64'(dcount));
      check("rst_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_rows = 4'd0; cmd_cols = 4'd0;
      in_valid = 1'b0; in_row = '0;
      sa_result = '0; sa_result_valid = 1'b0; sa_done = 1'b0;
      res_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) clk_cycle();
      check_idle("reset");

      run_txn(2'd0, 4'd2, 4'd2, 2, 0, 100);
      bad_cmd(2'd0, 4'd0, 4'd3);
      bad_cmd(2'd2, 4'd2, 4'd2);
      bad_cmd(2'd1, 4'd3, 4'd0);
      run_txn(2'd1, 4'd1, 4'd3, 6, 0, 0);
      run_txn(2'd0, 4'd1, 4'd1, 7, 0, -1);
      run_txn(2'd0, 4'd2, 4'd4, 0, 2, 0);
      run_txn(2'd1, 4'd3, 4'd5, 0, 1, 0);
      reset_mid_feed();
      run_txn(2'd0, 4'd2, 4'd2, 3, 0, 50);

      for (int t = 0; t < 30; t++) begin
         int kind;
         logic [1:0] op;
         logic [3:0] rows, cols;
         kind = int'($urandom_range(0, 9));
         op   = 2'($urandom_range(0, 1));
         rows = 4'($urandom_range(1, 5));
         cols = 4'($urandom_range(1, 15));
         case (kind)
            0: bad_cmd(2'd2, rows, cols);
            1: bad_cmd(op, ($urandom_range(0, 1) == 0) ? 4'd0 : rows,
                       ($urandom_range(0, 1) == 0) ? cols : 4'd0);
            2: run_txn(op, rows, cols, 0, 1, 0);
            3: run_txn(op, rows, cols, 0, 2, 0);
            default: run_txn(op, rows, cols, int'($urandom_range(0, 7)), 0,
                             int'($urandom_range(0, 100)));
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameters: LANES, default 16, number of array lanes; DW, default 8, data/weight width; RW, default 16, result width; TMO, default 1023, wait-for-done timeout in cycles.
REQ-002 SHALL have ports, one clock and one synchronous active-high reset, as follows:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted
- cmd_op  in  2  0=matmul, 1=conv, 2=idle
- cmd_rows  in  4  row count
- cmd_cols  in  4  column count
- in_valid  in  1  input row offered
- in_ready  out  1  input row accepted
- in_row  in  LANES*DW  packed row, lane 0 in LSBs
- sa_start  out  1  array start pulse
- sa_operation  out  2  array operation
- sa_rows  out  4  array row count
- sa_cols  out  4  array column count
- sa_weight  out  LANES*DW  weight row
- sa_weight_valid  out  1  weight row valid
- sa_data  out  LANES*DW  data row
- sa_data_valid  out  1  data row valid
- sa_result  in  LANES*RW  array result row
- sa_result_valid  in  1  result row valid
- sa_done  in  1  array done
- res_valid  out  1  result FIFO head valid
- res_ready  in  1  consumer pop
- res_row  out  LANES*RW  FIFO head row
- res_index  out  4  head row index
- busy  out  1  transaction active
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  one-cycle rejected-command pulse
- err_overflow  out  1  sticky result drop
- err_timeout  out  1  sticky timeout

Function
REQ-003 SHALL implement states IDLE, START, LOAD_W, FEED_D, COLLECT, DONE.
REQ-004 IDLE: cmd_ready=1 and all other handshakes deasserted.
REQ-005 IDLE, cmd_valid with cmd_op=2, cmd_rows=0 or cmd_cols=0: consume command, pulse cmd_err next cycle, stay in IDLE.
REQ-006 IDLE, valid command: register op/rows/cols, clear err_overflow, err_timeout, FIFO and index counter, go to START.
REQ-007 sa_operation/sa_rows/sa_cols SHALL hold registered values from START until return to IDLE.
REQ-008 START: sa_start=1 for exactly one cycle, then LOAD_W.
REQ-009 LOAD_W: in_ready=1.
- Each in_valid&&in_ready beat registers in_row to sa_weight, with sa_weight_valid=1 the following cycle only.
- After rows beats, go to FEED_D.
REQ-010 FEED_D: identical handshake driving sa_data/sa_data_valid.
- After rows beats, go to COLLECT.
- in_ready=0 in all other states.
REQ-011 In START through COLLECT, each sa_result_valid cycle SHALL push sa_result and a 4-bit index (mod 16) into a 4-entry FIFO.
REQ-012 Push with FIFO full and no simultaneous pop: drop row, set err_overflow.
- Push and pop in the same cycle when full: legal, no drop.
REQ-013 res_valid = FIFO non-empty; res_ready&&res_valid pops; res_row/res_index reflect the head with zero latency.
REQ-014 COLLECT: wait for sa_done, then go to DONE.
- A TMO-cycle counter runs from COLLECT entry; on expiry set err_timeout and go to IDLE without a done pulse.
REQ-015 sa_done observed before COLLECT SHALL be latched and honoured on COLLECT entry.
REQ-016 DONE: done=1 for one cycle, then IDLE; the FIFO keeps draining in IDLE.
REQ-017 busy=1 in every state except IDLE.

Reset
REQ-018 rst SHALL be sampled only on rising clk edges.
REQ-019 On reset: state=IDLE, FIFO empty, counters cleared; every output 0 except cmd_ready=1.
REQ-020 Reset asserted mid-transaction SHALL abort it, with no further sa_* pulses.

Verification
REQ-021 Reset, then idle 5 cycles -> cmd_ready=1, all other outputs 0.
REQ-022 cmd op=0 rows=2 cols=2, 2 weight rows then 2 data rows, model emits 2 results then sa_done -> one sa_start, 2 sa_weight_valid, 2 sa_data_valid, res_index 0,1 in order, single done pulse.
REQ-023 cmd_rows=0 -> cmd_err pulse, no sa_start, busy stays 0.
REQ-024 res_ready=0, model emits 6 result rows -> 4 rows retained (indices 0-3), err_overflow=1.
REQ-025 sa_done withheld -> err_timeout=1 exactly TMO cycles after COLLECT entry, no done pulse, state IDLE.
REQ-026 rst asserted during FEED_D -> next cycle all outputs at reset values; a new command completes normally.
